glyph_lock_tracker: RTL and testbench

//   Consumes the predicted_glyph/predict_valid stream from the Kalman predictor stage.

---
 rtl/glyph_lock_tracker.sv | 195 +++++++++++++++++++
 tb/tb_glyph_lock_tracker.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/glyph_lock_tracker.sv
// Lock tracker: judges predictor stability and forwards locked, stable glyphs through a FWFT FIFO.
// Define GLYPH_LOCK_STATS_EN to add saturating lock_count/drop_count statistics outputs.
module glyph_lock_tracker #(
    parameter int unsigned      WIDTH      = 16,
    parameter logic [WIDTH-1:0] LOCK_TOL   = WIDTH'(64),
    parameter int unsigned      LOCK_COUNT = 4,
    parameter int unsigned      LOSE_COUNT = 2,
    parameter int unsigned      FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] predicted_glyph,
    input  logic             predict_valid,
    output logic [WIDTH-1:0] glyph_out,
    output logic             glyph_valid,
    input  logic             glyph_ready,
    output logic             locked,
    output logic [1:0]       lock_state,
`ifdef GLYPH_LOCK_STATS_EN
    output logic [15:0]      lock_count,
    output logic [15:0]      drop_count,
`endif
    output logic             overflow
);

    localparam int unsigned RunW  = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MissW = $clog2(LOSE_COUNT + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW  = PtrW + 1;

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StAcquire = 2'b01,
        StLocked  = 2'b10,
        StLost    = 2'b11
    } state_e;

    state_e             state_q, state_d;
    logic [RunW-1:0]    run_q, run_d;
    logic [MissW-1:0]   miss_q, miss_d;
    logic [WIDTH-1:0]   prev_q, prev_d;
    logic               have_prev_q, have_prev_d;
    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               overflow_q, overflow_d;

    logic [WIDTH:0]     delta;
    logic               stable;
    logic [RunW-1:0]    acq_run, acq_inc;
    logic [MissW-1:0]   miss_inc;
    logic               push_req, push_ok, pop, full;

    // Absolute step in WIDTH+1 bits so a full-scale jump never wraps to a small delta.
    always_comb begin
        if (predicted_glyph >= prev_q) begin
            delta = {1'b0, predicted_glyph} - {1'b0, prev_q};
        end else begin
            delta = {1'b0, prev_q} - {1'b0, predicted_glyph};
        end
        stable = have_prev_q && (delta <= {1'b0, LOCK_TOL});
    end

    assign acq_run  = (state_q == StLost) ? '0 : run_q;
    assign acq_inc  = acq_run + RunW'(1);
    assign miss_inc = miss_q + MissW'(1);

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        miss_d      = miss_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        push_req    = 1'b0;
        if (predict_valid) begin
            prev_d      = predicted_glyph;
            have_prev_d = 1'b1;
            unique case (state_q)
                StIdle: begin
                    state_d = StAcquire;
                    run_d   = '0;
                end
                StAcquire, StLost: begin
                    if (stable && (acq_inc == RunW'(LOCK_COUNT))) begin
                        state_d  = StLocked;
                        miss_d   = '0;
                        push_req = 1'b1;
                    end else begin
                        state_d = StAcquire;
                        run_d   = stable ? acq_inc : '0;
                    end
                end
                StLocked: begin
                    if (stable) begin
                        push_req = 1'b1;
                        miss_d   = '0;
                    end else begin
                        miss_d = miss_inc;
                        if (miss_inc == MissW'(LOSE_COUNT)) begin
                            state_d = StLost;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        full       = (count_q == CntW'(FIFO_DEPTH));
        pop        = (count_q != '0) && glyph_ready;
        push_ok    = push_req && (!full || pop);
        overflow_d = push_req && full && !pop;
        wr_ptr_d   = wr_ptr_q + PtrW'(push_ok);
        rd_ptr_d   = rd_ptr_q + PtrW'(pop);
        count_d    = count_q + CntW'(push_ok) - CntW'(pop);
        out_d      = out_q;
        // Head is the in-flight write only when it becomes the sole entry this cycle.
        if (count_d != '0) begin
            if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
                out_d = predicted_glyph;
            end else begin
                out_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            run_q       <= '0;
            miss_q      <= '0;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_q       <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            miss_q      <= miss_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_q       <= out_d;
            overflow_q  <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wr_ptr_q] <= predicted_glyph;
        end
    end

    assign glyph_out   = out_q;
    assign glyph_valid = (count_q != '0);
    assign locked      = (state_q == StLocked);
    assign lock_state  = state_q;
    assign overflow    = overflow_q;

`ifdef GLYPH_LOCK_STATS_EN
    logic [15:0] lock_count_q, lock_count_d, drop_count_q, drop_count_d;

    always_comb begin
        lock_count_d = lock_count_q;
        drop_count_d = drop_count_q;
        if ((state_d == StLocked) && (state_q != StLocked) && (lock_count_q != 16'hFFFF)) begin
            lock_count_d = lock_count_q + 16'd1;
        end
        if (overflow_d && (drop_count_q != 16'hFFFF)) begin
            drop_count_d = drop_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_count_q <= '0;
            drop_count_q <= '0;
        end else begin
            lock_count_q <= lock_count_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign lock_count = lock_count_q;
    assign drop_count = drop_count_q;
`endif

endmodule

// File: tb/tb_glyph_lock_tracker.sv
// Bench for glyph_lock_tracker: directed scenarios plus random traffic against a queue-based model.
module tb_glyph_lock_tracker;

    localparam int TOL   = 'h40;
    localparam int LOCKN = 4;
    localparam int LOSEN = 2;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] predicted_glyph = '0;
    logic        predict_valid = 1'b0;
    logic        glyph_ready = 1'b0;
    logic [15:0] glyph_out;
    logic        glyph_valid;
    logic        locked;
    logic [1:0]  lock_state;
    logic        overflow;
`ifdef GLYPH_LOCK_STATS_EN
    logic [15:0] lock_count, drop_count;
`endif

    glyph_lock_tracker dut (
        .clk             (clk),
        .rst             (rst),
        .predicted_glyph (predicted_glyph),
        .predict_valid   (predict_valid),
        .glyph_out       (glyph_out),
        .glyph_valid     (glyph_valid),
        .glyph_ready     (glyph_ready),
        .locked          (locked),
        .lock_state      (lock_state),
`ifdef GLYPH_LOCK_STATS_EN
        .lock_count      (lock_count),
        .drop_count      (drop_count),
`endif
        .overflow        (overflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: state 0..3 = idle/acquire/locked/lost; run/miss as plain integers.
    int          m_state, m_run, m_miss, m_lockc, m_dropc;
    logic [15:0] m_prev, m_out;
    bit          m_have, m_ovf;
    logic [15:0] m_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit v, input logic [15:0] g, input bit rd);
        bit pop, push, stable;
        int d, base;
        if (r) begin
            m_state = 0; m_run = 0; m_miss = 0; m_have = 0; m_prev = 0;
            m_q.delete(); m_out = 0; m_ovf = 0; m_lockc = 0; m_dropc = 0;
            return;
        end
        pop  = (m_q.size() > 0) && rd;
        push = 0;
        if (v) begin
            d = int'(g) - int'(m_prev);
            if (d < 0) d = -d;
            stable = m_have && (d <= TOL);
            case (m_state)
                0: begin m_state = 1; m_run = 0; end
                1, 3: begin
                    base = (m_state == 3) ? 0 : m_run;
                    if (stable && base + 1 == LOCKN) begin
                        m_state = 2; m_miss = 0; push = 1;
                        if (m_lockc < 'hFFFF) m_lockc++;
                    end else begin
                        m_state = 1;
                        m_run = stable ? base + 1 : 0;
                    end
                end
                default: begin
                    if (stable) begin
                        push = 1; m_miss = 0;
                    end else begin
                        m_miss++;
                        if (m_miss == LOSEN) m_state = 3;
                    end
                end
            endcase
            m_prev = g;
            m_have = 1;
        end
        m_ovf = push && (m_q.size() == DEPTH) && !pop;
        if (m_ovf && m_dropc < 'hFFFF) m_dropc++;
        if (pop) void'(m_q.pop_front());
        if (push && !m_ovf) m_q.push_back(g);
        if (m_q.size() > 0) m_out = m_q[0];
    endtask

    task automatic check_all();
        chk("valid", {31'd0, glyph_valid}, {31'd0, m_q.size() != 0});
        chk("glyph_out", {16'd0, glyph_out}, {16'd0, m_out});
        chk("lock_state", {30'd0, lock_state}, m_state);
        chk("locked", {31'd0, locked}, {31'd0, m_state == 2});
        chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef GLYPH_LOCK_STATS_EN
        chk("lock_count", {16'd0, lock_count}, m_lockc);
        chk("drop_count", {16'd0, drop_count}, m_dropc);
`endif
    endtask

    task automatic cyc(input bit r, input bit v, input logic [15:0] g, input bit rd);
        rst = r; predict_valid = v; predicted_glyph = g; glyph_ready = rd;
        @(posedge clk);
        model_step(r, v, g, rd);
        #1;
        check_all();
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] g;
        // Reset
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        chk("rst_valid", {31'd0, glyph_valid}, 0);
        chk("rst_out", {16'd0, glyph_out}, 0);
        chk("rst_state", {30'd0, lock_state}, 0);

        // 1: lock after four stable steps
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0100 + 16'(i), 1);
        chk("t1_not_locked", {31'd0, locked}, 0);
        cyc(0, 1, 16'h0104, 1);
        chk("t1_locked", {30'd0, lock_state}, 2);
        chk("t1_out", {16'd0, glyph_out}, 32'h104);
        chk("t1_valid", {31'd0, glyph_valid}, 1);

        // 2: lose lock on two unstable samples
        cyc(0, 1, 16'h0104, 1);
        cyc(0, 1, 16'h0400, 1);
        chk("t2_miss1", {30'd0, lock_state}, 2);
        cyc(0, 1, 16'h0900, 1);
        chk("t2_lost", {30'd0, lock_state}, 3);
        chk("t2_empty", {31'd0, glyph_valid}, 0);

        // 3: overflow with ready low, then drain in order
        cyc(0, 1, 16'h0900, 1);
        chk("t3_acq", {30'd0, lock_state}, 1);
        for (int i = 1; i < 4; i++) cyc(0, 1, 16'h0900 + 16'(i), 1);
        chk("t3_relock", {31'd0, locked}, 1);
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 1, 16'h0910 + 16'(i), 0);
            chk("t3_ovf", {31'd0, overflow}, {31'd0, i >= 4});
        end
        chk("t3_head", {16'd0, glyph_out}, 32'h910);
        for (int i = 1; i < 4; i++) begin
            cyc(0, 0, 0, 1);
            chk("t3_drain", {16'd0, glyph_out}, 32'h910 + i);
        end
        cyc(0, 0, 0, 1);
        chk("t3_drained", {31'd0, glyph_valid}, 0);

        // 4: full FIFO, simultaneous push and pop
        for (int i = 0; i < 4; i++) cyc(0, 1, 16'h0920 + 16'(i), 0);
        cyc(0, 1, 16'h0924, 1);
        chk("t4_no_ovf", {31'd0, overflow}, 0);
        chk("t4_head", {16'd0, glyph_out}, 32'h921);
        for (int i = 2; i < 5; i++) begin
            cyc(0, 0, 0, 1);
            chk("t4_order", {16'd0, glyph_out}, 32'h920 + i);
        end
        cyc(0, 0, 0, 1);

        // 5: reset while locked with queued entries
        for (int i = 0; i < 3; i++) cyc(0, 1, 16'h0930 + 16'(i), 0);
        chk("t5_queued", {31'd0, glyph_valid}, 1);
        cyc(1, 0, 0, 0);
        chk("t5_valid", {31'd0, glyph_valid}, 0);
        chk("t5_locked", {31'd0, locked}, 0);
        chk("t5_state", {30'd0, lock_state}, 0);

        // 6: tolerance boundary and full-scale jump
        cyc(0, 1, 16'h0000, 1);
        cyc(0, 1, 16'h0041, 1);
        cyc(0, 1, 16'h0081, 1);
        cyc(0, 1, 16'h00C1, 1);
        cyc(0, 1, 16'h0101, 1);
        chk("t6_tol_plus1", {31'd0, locked}, 0);
        cyc(0, 1, 16'h0141, 1);
        chk("t6_tol_exact", {31'd0, locked}, 1);
        cyc(0, 1, 16'hFFFF, 1);
        cyc(0, 1, 16'h0000, 1);
        chk("t6_wrap", {30'd0, lock_state}, 3);

        // Random traffic
        g = 16'h1000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) < 8) g = g + 16'($urandom_range(0, 'h90)) - 16'h0048;
            else g = 16'($urandom);
            cyc($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, g,
                $urandom_range(0, 9) < 5);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
